// File: rtl/uart_pkg.sv
// Shared constants, state encodings and baud-divider helper for the UART command receive path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [7:0]  CMD_HEADER = 8'hA5;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_X, P_Y, P_SUM} pkt_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: rxd synchronizer, 16x oversample tick generator and byte framing FSM.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       tick_c
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic          rxd_meta_q, rxd_sync_q;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  rx_state_t     state_q, state_d;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          maj_c;

  assign tick_c    = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick_c ? '0 : div_cnt_q + CW'(1);

  // Samples at sc = 7 and 8 are stored; the sc = 9 sample is the live synced input.
  assign maj_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) | (samp_q[1] & rxd_sync_q);

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    samp_d       = samp_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (tick_c) begin
      if (sc_q == 4'd7) samp_d[0] = rxd_sync_q;
      if (sc_q == 4'd8) samp_d[1] = rxd_sync_q;
      sc_d = sc_q + 4'd1;
      case (state_q)
        IDLE: begin
          sc_d = '0;
          if (!rxd_sync_q) state_d = START;
        end
        START: begin
          if (sc_q == 4'd9 && maj_c) begin
            state_d = IDLE;
          end else if (sc_q == 4'd15) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (sc_q == 4'd9) shift_d = {maj_c, shift_q[7:1]};
          if (sc_q == 4'd15) begin
            if (bit_idx_q == 3'd7) state_d = STOP;
            else bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        // Decide early so a start bit immediately after the stop bit is caught in IDLE.
        STOP: begin
          if (sc_q == 4'd9) begin
            if (maj_c) begin
              byte_data_d  = shift_q;
              byte_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end
        end
        BREAK: begin
          sc_d = '0;
          if (rxd_sync_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      div_cnt_q    <= '0;
      state_q      <= IDLE;
      sc_q         <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd;
      rxd_sync_q   <= rxd_meta_q;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_command_receiver.sv
// Host position-command receiver: validates {A5, x, y, x^y} packets and presents the (x, y) target.
module uart_command_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned TIMEOUT_TICKS = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] cmd_x,
  output logic [7:0] cmd_y,
  output logic       cmd_valid,
  output logic       cmd_err
);

  localparam int unsigned GW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] CMD_DEFAULT = 8'd2;

  logic          rx_tick_c;
  pkt_state_t    pkt_state_q, pkt_state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    x_tmp_q, x_tmp_d, y_tmp_q, y_tmp_d;
  logic [7:0]    cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
  logic          cmd_valid_q, cmd_valid_d, cmd_err_q, cmd_err_d;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .tick_c     (rx_tick_c)
  );

  // A received byte takes priority over both frame errors and the gap timeout.
  always_comb begin
    pkt_state_d = pkt_state_q;
    gap_d       = gap_q;
    x_tmp_d     = x_tmp_q;
    y_tmp_d     = y_tmp_q;
    cmd_x_d     = cmd_x_q;
    cmd_y_d     = cmd_y_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    if (byte_valid) begin
      gap_d = '0;
      case (pkt_state_q)
        P_HDR: if (byte_data == CMD_HEADER) pkt_state_d = P_X;
        P_X: begin
          x_tmp_d     = byte_data;
          pkt_state_d = P_Y;
        end
        P_Y: begin
          y_tmp_d     = byte_data;
          pkt_state_d = P_SUM;
        end
        P_SUM: begin
          if (byte_data == (x_tmp_q ^ y_tmp_q)) begin
            cmd_x_d     = x_tmp_q;
            cmd_y_d     = y_tmp_q;
            cmd_valid_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
          pkt_state_d = P_HDR;
        end
        default: pkt_state_d = P_HDR;
      endcase
    end else if (pkt_state_q != P_HDR) begin
      if (frame_err) begin
        cmd_err_d   = 1'b1;
        pkt_state_d = P_HDR;
        gap_d       = '0;
      end else if (rx_tick_c) begin
        if (gap_q == GAP_LAST) begin
          cmd_err_d   = 1'b1;
          pkt_state_d = P_HDR;
          gap_d       = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_state_q <= P_HDR;
      gap_q       <= '0;
      x_tmp_q     <= '0;
      y_tmp_q     <= '0;
      cmd_x_q     <= CMD_DEFAULT;
      cmd_y_q     <= CMD_DEFAULT;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      pkt_state_q <= pkt_state_d;
      gap_q       <= gap_d;
      x_tmp_q     <= x_tmp_d;
      y_tmp_q     <= y_tmp_d;
      cmd_x_q     <= cmd_x_d;
      cmd_y_q     <= cmd_y_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign cmd_x     = cmd_x_q;
  assign cmd_y     = cmd_y_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;

endmodule
